riscv_alu_mul_serial: RTL and testbench
=======================================

# riscv_alu_mul_serial

Serial shift-add integer multiplier covering RV32M MUL/MULH/MULHSU/MULHU, the multiply counterpart to the ALU's serial divider. It shares that unit's operand/handshake style, so the EX stage can steer long-latency mul and div through the same valid/ready path. It retires one multiplier bit per cycle on operand magnitudes and applies the sign correction on the output.

## Interface
- C_WIDTH, 32: operand and result width.
- C_LOG_WIDTH, 6: counter width; must equal $clog2(C_WIDTH+1) (elaboration-time check).
- Clk_CI  in  1  clock; all state updates on rising edge.
- Rst_RI  in  1  reset, synchronous and active-high.
- OpA_DI  in  C_WIDTH  multiplicand.
- OpB_DI  in  C_WIDTH  multiplier.
- OpASign_SI  in  1  treat OpA_DI as signed (0 for MULHU).
- OpBSign_SI  in  1  treat OpB_DI as signed (0 for MULHSU/MULHU).
- HighSel_SI  in  1  0: low word of product (MUL), 1: high word.
- InVld_SI  in  1  operands valid.
- InRdy_SO  out  1  ready to accept; reset value 1.
- OutVld_SO  out  1  result valid; reset value 0.
- OutRdy_SI  in  1  consumer accepts result.
- Res_DO  out  C_WIDTH  result; reset value 0.

## Operation
- States: IDLE, MULTIPLY, FINISH. Reset forces IDLE and clears all registers.
- IDLE: InRdy_SO=1. On InVld_SI, the block latches the following, loads Cnt=C_WIDTH-1 and goes to MULTIPLY:
  - Sign flags: SA=OpA_DI[MSB]&OpASign_SI, SB=OpB_DI[MSB]&OpBSign_SI.
  - ResInv=SA^SB, and HighSel.
  - AReg (2*C_WIDTH) = zero-extended |A|.
  - BReg (C_WIDTH) = |B|.
  - Acc (2*C_WIDTH) = 0.
- Magnitudes are unsigned C_WIDTH values, so -2^(W-1) maps to 2^(W-1) with no overflow.
- MULTIPLY, each cycle:
  - Acc += AReg if BReg[0].
  - AReg <<= 1.
  - BReg >>= 1 (logical).
  - Cnt -= 1.
  - Exit to FINISH after the cycle in which Cnt==0.
- FINISH: OutVld_SO=1.
  - Res_DO = HighSel ? P[2W-1:W] : P[W-1:0], where P = ResInv ? -Acc : Acc (2W-bit two's complement).
  - Returns to IDLE on OutRdy_SI.
- Result and flags are held stable while OutVld_SO & ~OutRdy_SI.
- InVld_SI is ignored outside IDLE. InRdy_SO is 0 in MULTIPLY and FINISH.
- Res_DO outside FINISH is don't-care but deterministic: the combinational function of the current registers.
- Reset asserted mid-operation: the next cycle is IDLE with OutVld_SO=0 and no result emitted.

## Timing
- Accept at edge 0. MULTIPLY occupies cycles 1..N. OutVld_SO=1 from cycle N+1.
- N=C_WIDTH by default (FINISH at cycle 33 for 32 bits).
- Accepting a result and a new operand set in the same cycle is not possible. Minimum initiation interval is N+2 cycles.
- Output negation is combinational from registers; there is no extra cycle.

## Configuration
- MUL_EARLY_TERM_EN defined: MULTIPLY also exits to FINISH after any cycle in which the pre-shift BReg[C_WIDTH-1:1]==0.
  - N = max(1, index of MSB set in |B| + 1).
  - |B|=0 or 1 gives N=1.
  - Results are identical to the macro-undefined build.
- Undefined: fixed N=C_WIDTH regardless of operands.

## Structure
- The state enum (IDLE/MULTIPLY/FINISH) and the HighSel encoding constants go in the shared riscv_defines package, next to the divider's opcode constants.
- One sub-module: riscv_alu_mul_abs, a parameterized-width conditional two's-complement negator.
  - Used for |A|, for |B| and for the 2W product correction (three instances).

## Test plan
- MUL, A=7, B=6, signs 0, HighSel=0 -> Res_DO=42; OutVld_SO at cycle 33 (macro undefined), cycle 4 (defined, |B|=6 has MSB index 2 -> N=3).
- MULH signed, A=0x80000000, B=0x80000000 -> high word 0x40000000; MUL same operands -> 0x00000000.
- MULHSU, A=0xFFFFFFFF (-1), B=0xFFFFFFFF unsigned -> high word 0xFFFFFFFF, low word 0x00000001.
- MULHU, A=B=0xFFFFFFFF -> high 0xFFFFFFFE; hold OutRdy_SI=0 for 5 cycles -> Res_DO/OutVld_SO stable, InRdy_SO=0, InVld_SI pulses ignored.
- B=0, any A (macro defined) -> Res_DO=0 after exactly one MULTIPLY cycle; A=-3, B=0 signed -> 0, not a negated artifact.
- Assert Rst_RI at MULTIPLY cycle 10 -> next cycle IDLE, InRdy_SO=1, OutVld_SO=0, Res_DO=0; a fresh 5*-5 signed op then returns 0xFFFFFFE7.

Source files
------------

// File: rtl/riscv_defines.sv
// Shared ALU definitions for the serial long-latency units (multiplier
// state encoding and high/low product word select).
package riscv_defines;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MULTIPLY = 2'd1,
    FINISH   = 2'd2
  } mul_state_e;

  localparam logic HIGH_SEL_LO = 1'b0;
  localparam logic HIGH_SEL_HI = 1'b1;

endpackage

// File: rtl/riscv_alu_mul_abs.sv
// Conditional two's-complement negator: result = negate ? -value : value.
module riscv_alu_mul_abs #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/riscv_alu_mul_serial.sv
// Serial shift-add RV32M multiplier (MUL/MULH/MULHSU/MULHU), one multiplier
// bit per cycle on magnitudes. MUL_EARLY_TERM_EN: stop once |B| is exhausted.
module riscv_alu_mul_serial
  import riscv_defines::*;
#(
  parameter int unsigned C_WIDTH     = 32,
  parameter int unsigned C_LOG_WIDTH = 6
) (
  input  logic               Clk_CI,
  input  logic               Rst_RI,
  input  logic [C_WIDTH-1:0] OpA_DI,
  input  logic [C_WIDTH-1:0] OpB_DI,
  input  logic               OpASign_SI,
  input  logic               OpBSign_SI,
  input  logic               HighSel_SI,
  input  logic               InVld_SI,
  output logic               InRdy_SO,
  output logic               OutVld_SO,
  input  logic               OutRdy_SI,
  output logic [C_WIDTH-1:0] Res_DO
);

  generate
    if (C_LOG_WIDTH != $clog2(C_WIDTH+1)) begin : g_bad_log_width
      $error("C_LOG_WIDTH must equal $clog2(C_WIDTH+1)");
    end
  endgenerate

  mul_state_e               state;
  logic [2*C_WIDTH-1:0]     a_reg;
  logic [2*C_WIDTH-1:0]     acc;
  logic [C_WIDTH-1:0]       b_reg;
  logic [C_LOG_WIDTH-1:0]   cnt;
  logic                     res_inv;
  logic                     high_sel;
  logic                     sign_a;
  logic                     sign_b;
  logic                     last_cycle;
  logic [C_WIDTH-1:0]       a_mag;
  logic [C_WIDTH-1:0]       b_mag;
  logic [2*C_WIDTH-1:0]     prod;

  assign sign_a = OpA_DI[C_WIDTH-1] & OpASign_SI;
  assign sign_b = OpB_DI[C_WIDTH-1] & OpBSign_SI;

  riscv_alu_mul_abs #(.WIDTH(C_WIDTH)) i_abs_a (
    .value(OpA_DI), .negate(sign_a), .result(a_mag)
  );

  riscv_alu_mul_abs #(.WIDTH(C_WIDTH)) i_abs_b (
    .value(OpB_DI), .negate(sign_b), .result(b_mag)
  );

  // Sign correction on the full 2W product; zero stays zero under negation.
  riscv_alu_mul_abs #(.WIDTH(2*C_WIDTH)) i_abs_p (
    .value(acc), .negate(res_inv), .result(prod)
  );

`ifdef MUL_EARLY_TERM_EN
  assign last_cycle = (cnt == '0) || (b_reg[C_WIDTH-1:1] == '0);
`else
  assign last_cycle = (cnt == '0);
`endif

  assign Res_DO = (high_sel == HIGH_SEL_HI) ? prod[2*C_WIDTH-1:C_WIDTH]
                                            : prod[C_WIDTH-1:0];

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state     <= IDLE;
      a_reg     <= '0;
      acc       <= '0;
      b_reg     <= '0;
      cnt       <= '0;
      res_inv   <= 1'b0;
      high_sel  <= 1'b0;
      InRdy_SO  <= 1'b1;
      OutVld_SO <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (InVld_SI) begin
            a_reg    <= {{C_WIDTH{1'b0}}, a_mag};
            b_reg    <= b_mag;
            acc      <= '0;
            cnt      <= C_LOG_WIDTH'(C_WIDTH-1);
            res_inv  <= sign_a ^ sign_b;
            high_sel <= HighSel_SI;
            InRdy_SO <= 1'b0;
            state    <= MULTIPLY;
          end
        end
        MULTIPLY: begin
          if (b_reg[0]) acc <= acc + a_reg;
          a_reg <= a_reg << 1;
          b_reg <= b_reg >> 1;
          cnt   <= cnt - C_LOG_WIDTH'(1);
          if (last_cycle) begin
            OutVld_SO <= 1'b1;
            state     <= FINISH;
          end
        end
        FINISH: begin
          if (OutRdy_SI) begin
            OutVld_SO <= 1'b0;
            InRdy_SO  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          OutVld_SO <= 1'b0;
          InRdy_SO  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_alu_mul_serial.sv
// Self-checking bench for riscv_alu_mul_serial: directed table, corner
// sequences and random operands against an arithmetic reference model.
module tb_riscv_alu_mul_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        a_sign = 1'b0;
  logic        b_sign = 1'b0;
  logic        high_sel = 1'b0;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic        out_vld;
  logic        out_rdy = 1'b0;
  logic [31:0] res;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_alu_mul_serial #(.C_WIDTH(32), .C_LOG_WIDTH(6)) dut (
    .Clk_CI(clk), .Rst_RI(rst),
    .OpA_DI(op_a), .OpB_DI(op_b),
    .OpASign_SI(a_sign), .OpBSign_SI(b_sign), .HighSel_SI(high_sel),
    .InVld_SI(in_vld), .InRdy_SO(in_rdy),
    .OutVld_SO(out_vld), .OutRdy_SI(out_rdy),
    .Res_DO(res)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        as;
    logic        bs;
    logic        hi;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: sign/zero-extend to 64 bits and multiply; low 64 bits are exact.
  function automatic logic [31:0] model_res(input logic [31:0] a, input logic [31:0] b,
                                            input logic as, input logic bs, input logic hi);
    longint ea, eb;
    logic [63:0] p;
    ea = as ? longint'($signed(a)) : longint'({32'h0, a});
    eb = bs ? longint'($signed(b)) : longint'({32'h0, b});
    p  = 64'(ea * eb);
    return hi ? p[63:32] : p[31:0];
  endfunction

  function automatic int model_lat(input logic [31:0] b, input logic bs);
`ifdef MUL_EARLY_TERM_EN
    logic [31:0] m;
    int n;
    m = (bs && b[31]) ? (32'h0 - b) : b;
    n = 1;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    return n;
`else
    if (bs && b[31]) return 32;
    return 32;
`endif
  endfunction

  // Launch one op and wait for OutVld; returns result and edges-to-valid.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic as, input logic bs, input logic hi,
                          output logic [31:0] r, output int lat);
    @(negedge clk);
    op_a = a; op_b = b; a_sign = as; b_sign = bs; high_sel = hi; in_vld = 1'b1;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    lat = 0;
    while (!out_vld && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = res;
  endtask

  task automatic accept_result();
    @(negedge clk);
    out_rdy = 1'b1;
    @(posedge clk);
    #1;
    out_rdy = 1'b0;
    check("post_accept_outvld", 32'(out_vld), 32'd0);
    check("post_accept_inrdy", 32'(in_rdy), 32'd1);
  endtask

  task automatic run_checked(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic as, input logic bs, input logic hi,
                             input logic [31:0] exp);
    logic [31:0] r;
    int lat;
    start_op(a, b, as, bs, hi, r, lat);
    check({name, "_res"}, r, exp);
    check({name, "_lat"}, 32'(lat), 32'(model_lat(b, bs)));
    accept_result();
  endtask

  initial begin
    logic [31:0] r, held, ra, rb;
    logic        ras, rbs, rhi;
    int lat;

    vecs[0] = '{32'd7,        32'd6,        1'b0, 1'b0, 1'b0, 32'd42};
    vecs[1] = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b1, 32'h40000000};
    vecs[2] = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b0, 32'h00000000};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'h00000001};
    vecs[5] = '{32'hFFFFFFFD, 32'h00000000, 1'b1, 1'b1, 1'b0, 32'h00000000};
    vecs[6] = '{32'hFFFFFFFD, 32'h00000000, 1'b1, 1'b1, 1'b1, 32'h00000000};
    vecs[7] = '{32'h12345678, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h12345678};
    vecs[8] = '{32'd5,        32'hFFFFFFFB, 1'b1, 1'b1, 1'b0, 32'hFFFFFFE7};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_inrdy", 32'(in_rdy), 32'd1);
    check("reset_outvld", 32'(out_vld), 32'd0);
    check("reset_res", res, 32'd0);

    for (int i = 0; i < 9; i++)
      run_checked($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                  vecs[i].as, vecs[i].bs, vecs[i].hi, vecs[i].exp);

    // MULHU with stalled consumer: output held, new operands ignored.
    start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, held, lat);
    check("mulhu_res", held, 32'hFFFFFFFE);
    check("mulhu_lat", 32'(lat), 32'(model_lat(32'hFFFFFFFF, 1'b0)));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_vld = k[0] ? 1'b0 : 1'b1;
      op_a = 32'd3; op_b = 32'd3; high_sel = 1'b0;
      @(posedge clk);
      #1;
      check("hold_res", res, 32'hFFFFFFFE);
      check("hold_outvld", 32'(out_vld), 32'd1);
      check("hold_inrdy", 32'(in_rdy), 32'd0);
    end
    in_vld = 1'b0;
    accept_result();
    repeat (2) @(posedge clk);
    #1;
    check("ignored_pulse_idle", 32'(in_rdy), 32'd1);

    // Reset during MULTIPLY cycle 10.
    @(negedge clk);
    op_a = 32'd9; op_b = 32'hFFFFFFFF; a_sign = 1'b0; b_sign = 1'b0; high_sel = 1'b1;
    in_vld = 1'b1;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    check("busy_inrdy", 32'(in_rdy), 32'd0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_inrdy", 32'(in_rdy), 32'd1);
    check("midrst_outvld", 32'(out_vld), 32'd0);
    check("midrst_res", res, 32'd0);
    run_checked("post_rst", 32'd5, 32'hFFFFFFFB, 1'b1, 1'b1, 1'b0, 32'hFFFFFFE7);

    // Random operands and modes against the model.
    for (int n = 0; n < 40; n++) begin
      ra  = $urandom;
      rb  = (n % 4 == 0) ? ($urandom & 32'h000000FF) : $urandom;
      ras = 1'($urandom_range(0, 1));
      rbs = ras ? 1'($urandom_range(0, 1)) : 1'b0;
      rhi = 1'($urandom_range(0, 1));
      start_op(ra, rb, ras, rbs, rhi, r, lat);
      check("rand_res", r, model_res(ra, rb, ras, rbs, rhi));
      check("rand_lat", 32'(lat), 32'(model_lat(rb, rbs)));
      accept_result();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
